axi_stream_arbiter: RTL and testbench
=====================================

// Module: axi_stream_arbiter
// PURPOSE
//   Packet-level N:1 AXI-Stream arbiter sharing one downstream stream among NUM_INPUTS sources.
//   Grants one input per packet and holds the grant until its tlast beat completes.
//   Arbitration is round-robin, or fixed priority when the optional macro is set.
//   Sits ahead of a shared stream consumer such as a DMA, FIFO or serializer.
// PARAMETERS
//   NUM_INPUTS  4   number of slave inputs (>=2); IDX_W = $clog2(NUM_INPUTS) is local
//   DATA_WIDTH  32  tdata width (multiple of 8); tkeep width is DATA_WIDTH/8
//   USER_WIDTH  1   tuser width
//   ID_WIDTH    1   tid width
// PORTS
//   clk          in   1                        single clock; all logic on rising edge
//   rst          in   1                        synchronous, active-high reset
//   s_tdata      in   NUM_INPUTS*DATA_WIDTH    input i occupies [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid     in   NUM_INPUTS               per-input valid
//   s_tready     out  NUM_INPUTS               per-input ready
//   s_tlast      in   NUM_INPUTS               per-input end of packet
//   s_tkeep      in   NUM_INPUTS*DATA_WIDTH/8  per-input byte keep
//   s_tuser      in   NUM_INPUTS*USER_WIDTH    per-input user sideband
//   s_tid        in   NUM_INPUTS*ID_WIDTH      per-input stream id
//   m_tdata      out  DATA_WIDTH               muxed data
//   m_tvalid     out  1                        muxed valid
//   m_tready     in   1                        downstream ready
//   m_tlast      out  1                        muxed last
//   m_tkeep      out  DATA_WIDTH/8             muxed keep
//   m_tuser      out  USER_WIDTH               muxed user
//   m_tid        out  ID_WIDTH                 muxed id
//   grant_valid  out  1                        1 while a packet grant is held
//   grant_idx    out  IDX_W                    index of the granted input
// BEHAVIOUR
//   - Reset: state=IDLE; grant_valid=0; grant_idx=0; rr_ptr=0.
//     Outputs under reset: m_tvalid=0, s_tready=0, all m_* payload = 0.
//   - State IDLE:
//     - m_tvalid=0; s_tready=all 0; m_* payload=0.
//     - If any s_tvalid: pick a winner; next cycle state=BUSY, grant_idx=winner, grant_valid=1.
//     - Arbitration latency: 1 cycle from valid to first possible m_tvalid.
//   - Round-robin pick: first asserted s_tvalid scanning rr_ptr, rr_ptr+1, ... modulo NUM_INPUTS.
//     - On grant, rr_ptr <= winner+1, wrapping to 0 after NUM_INPUTS-1.
//   - State BUSY (combinational pass-through of granted input g, zero latency):
//     - m_tvalid=s_tvalid[g]; s_tready[g]=m_tready; s_tready[others]=0.
//     - m_tdata/tlast/tkeep/tuser/tid = slice g.
//   - Packet end: beat with m_tvalid & m_tready & m_tlast -> next cycle IDLE, grant_valid=0.
//     - grant_idx holds its last value.
//     - One idle bubble cycle is required between packets.
//   - Mid-packet: source dropping s_tvalid[g] stalls output (m_tvalid=0); grant is held.
//     - No timeout; other requesters wait.
//   - Single-beat packet (tlast on first beat) is legal; BUSY lasts one accepted beat.
//   - Requests arriving during BUSY are ignored until IDLE; no request is lost (sources hold valid).
//   - Reset asserted mid-packet: abort immediately to reset state; packet is truncated.
//     - No recovery beat is generated.
//   - Unsized case: NUM_INPUTS not a power of 2; pointer wrap is explicit, not bit overflow.
// CONFIGURATION
//   AXIS_ARB_FIXED_PRIORITY_EN defined:
//     - winner = lowest-index asserted s_tvalid; rr_ptr unused and held at 0.
//   Not defined (default):
//     - round-robin as above.
// TESTING
//   1. Reset: rst=1 for 2 cycles, all s_tvalid=1 -> m_tvalid=0, s_tready=0, grant_valid=0.
//   2. Single source: in1 sends a 3-beat packet 0xA1,0xA2,0xA3(last), m_tready=1
//      -> grant_idx=1 one cycle later; 3 output beats in order; IDLE after last.
//   3. Round-robin fairness: inputs 0..3 continuously valid with 2-beat packets
//      -> grant order 0,1,2,3,0.
//      - with AXIS_ARB_FIXED_PRIORITY_EN: order 0,0,0.
//   4. Backpressure: m_tready toggles 1,0,1,0 during a 4-beat packet
//      -> no beat duplicated or dropped; s_tready[g] mirrors m_tready; others 0.
//   5. Lock: in0 mid-packet drops valid 3 cycles while in2 valid
//      -> grant stays 0, m_tvalid=0 for 3 cycles, in2 granted only after in0 tlast.
//   6. Reset mid-packet on beat 2 of 4 -> next cycle IDLE, grant_valid=0.
//      - Fresh arbitration after release, rr_ptr=0.

Source files
------------

// File: rtl/axi_stream_arbiter_if.sv
// AXI-Stream bundle shared by the arbiter's upstream and downstream sides.
// LANES packs several parallel streams side by side. Lane i occupies slice i of every field.
// The master modport drives payload and valid. The slave modport drives ready.
interface axi_stream_arbiter_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 1
);
    logic [LANES*DATA_WIDTH-1:0]   tdata;
    logic [LANES-1:0]              tvalid;
    logic [LANES-1:0]              tready;
    logic [LANES-1:0]              tlast;
    logic [LANES*DATA_WIDTH/8-1:0] tkeep;
    logic [LANES*USER_WIDTH-1:0]   tuser;
    logic [LANES*ID_WIDTH-1:0]     tid;

    modport master (
        output tdata, tvalid, tlast, tkeep, tuser, tid,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tkeep, tuser, tid,
        output tready
    );
endinterface

// File: rtl/axi_stream_arbiter.sv
// Packet-level N:1 AXI-Stream arbiter.
// One upstream lane owns the downstream stream from its first beat until its tlast beat is accepted.
// A single idle bubble cycle separates consecutive packets.
// The default build arbitrates round-robin.
// Defining AXIS_ARB_FIXED_PRIORITY_EN switches arbitration to fixed priority, where the lowest index wins.
module axi_stream_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    localparam int IDX_W     = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_stream_arbiter_if.slave   s_if,
    axi_stream_arbiter_if.master  m_if,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  grantIdx_q, grantIdx_d;
    logic [IDX_W-1:0]  winnerIdx;
    logic              anyValid;

`ifndef AXIS_ARB_FIXED_PRIORITY_EN
    localparam logic [IDX_W:0]   NUM_L    = (IDX_W+1)'(NUM_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    logic [IDX_W-1:0]  rrPtr_q, rrPtr_d;
    logic [IDX_W:0]    candIdx;
    logic              found;
`endif

    assign anyValid    = |s_if.tvalid;
    assign grant_valid = (state_q == BUSY);
    assign grant_idx   = grantIdx_q;

`ifdef AXIS_ARB_FIXED_PRIORITY_EN
    // Winner is the lowest-index requester. Scan downward so that the last hit is the lowest index.
    always_comb begin
        winnerIdx = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (s_if.tvalid[i]) begin
                winnerIdx = IDX_W'(i);
            end
        end
    end
`else
    // Winner is the first requester found scanning upward from the round-robin pointer.
    // The wrap is explicit because NUM_INPUTS need not be a power of two.
    always_comb begin
        winnerIdx = '0;
        candIdx   = '0;
        found     = 1'b0;
        for (int off = 0; off < NUM_INPUTS; off++) begin
            candIdx = {1'b0, rrPtr_q} + off[IDX_W:0];
            if (candIdx >= NUM_L) begin
                candIdx = candIdx - NUM_L;
            end
            if (!found && s_if.tvalid[candIdx[IDX_W-1:0]]) begin
                found     = 1'b1;
                winnerIdx = candIdx[IDX_W-1:0];
            end
        end
    end
`endif

    // State, grant and pointer registers. A synchronous reset drops any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grantIdx_q <= '0;
`ifndef AXIS_ARB_FIXED_PRIORITY_EN
            rrPtr_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grantIdx_q <= grantIdx_d;
`ifndef AXIS_ARB_FIXED_PRIORITY_EN
            rrPtr_q    <= rrPtr_d;
`endif
        end
    end

    // Grant on any request while idle. Release after the accepted tlast beat.
    always_comb begin
        state_d    = state_q;
        grantIdx_d = grantIdx_q;
`ifndef AXIS_ARB_FIXED_PRIORITY_EN
        rrPtr_d    = rrPtr_q;
`endif
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    state_d    = BUSY;
                    grantIdx_d = winnerIdx;
`ifndef AXIS_ARB_FIXED_PRIORITY_EN
                    rrPtr_d    = (winnerIdx == LAST_IDX) ? '0 : winnerIdx + 1'b1;
`endif
                end
            end
            BUSY: begin
                if (m_if.tvalid[0] && m_if.tready[0] && m_if.tlast[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-latency pass-through of the granted lane. Everything is zero while idle or in reset.
    always_comb begin
        s_if.tready = '0;
        m_if.tvalid = '0;
        m_if.tlast  = '0;
        m_if.tdata  = '0;
        m_if.tkeep  = '0;
        m_if.tuser  = '0;
        m_if.tid    = '0;
        if (!rst && state_q == BUSY) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (grantIdx_q == IDX_W'(i)) begin
                    m_if.tvalid[0]  = s_if.tvalid[i];
                    m_if.tlast[0]   = s_if.tlast[i];
                    m_if.tdata      = s_if.tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    m_if.tkeep      = s_if.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                    m_if.tuser      = s_if.tuser[i*USER_WIDTH +: USER_WIDTH];
                    m_if.tid        = s_if.tid[i*ID_WIDTH +: ID_WIDTH];
                    s_if.tready[i]  = m_if.tready[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_arbiter.sv
// Directed self-checking bench for axi_stream_arbiter.
// The bench covers reset, single source, arbitration order, backpressure, packet lock and reset mid-packet.
// Expected grant order follows AXIS_ARB_FIXED_PRIORITY_EN when the macro is defined.
module tb_axi_stream_arbiter;

    localparam int NI = 4;
    localparam int DW = 32;

    logic       clk;
    logic       rst;
    logic       grantValid;
    logic [1:0] grantIdx;
    int         passCount;
    int         checkCount;

    axi_stream_arbiter_if #(.LANES(NI), .DATA_WIDTH(DW), .USER_WIDTH(1), .ID_WIDTH(1)) sBus ();
    axi_stream_arbiter_if #(.LANES(1),  .DATA_WIDTH(DW), .USER_WIDTH(1), .ID_WIDTH(1)) mBus ();

    axi_stream_arbiter #(
        .NUM_INPUTS (NI),
        .DATA_WIDTH (DW),
        .USER_WIDTH (1),
        .ID_WIDTH   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_if        (sBus),
        .m_if        (mBus),
        .grant_valid (grantValid),
        .grant_idx   (grantIdx)
    );

    // Free-running clock with rising edges at 5, 15, 25 and so on.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (passed=%0d total=%0d)", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic driveLane(input int lane, input logic valid, input logic [31:0] data, input logic last);
        sBus.tvalid[lane]        = valid;
        sBus.tdata[lane*32 +: 32] = data;
        sBus.tlast[lane]         = last;
        sBus.tkeep[lane*4 +: 4]  = 4'hF;
        sBus.tuser[lane]         = 1'b1;
        sBus.tid[lane]           = lane[0];
    endtask

    task automatic clearLanes;
        sBus.tvalid = '0;
        sBus.tdata  = '0;
        sBus.tlast  = '0;
        sBus.tkeep  = '0;
        sBus.tuser  = '0;
        sBus.tid    = '0;
    endtask

    task automatic doReset;
        @(negedge clk);
        rst = 1'b1;
        clearLanes();
        mBus.tready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mBus.tready = 1'b1;
        for (int i = 0; i < NI; i++) driveLane(i, 1'b1, 32'(i + 1), 1'b0);
        repeat (2) begin
            @(negedge clk); #1;
            checkCount++; if (mBus.tvalid !== 1'b0) $display("[TB] FAIL reset_m_tvalid got=%0h exp=0", mBus.tvalid); else passCount++;
            checkCount++; if (sBus.tready !== 4'b0000) $display("[TB] FAIL reset_s_tready got=%b exp=0000", sBus.tready); else passCount++;
            checkCount++; if (grantValid !== 1'b0) $display("[TB] FAIL reset_grant_valid got=%0h exp=0", grantValid); else passCount++;
            checkCount++; if (mBus.tdata !== 32'h0) $display("[TB] FAIL reset_m_tdata got=%0h exp=0", mBus.tdata); else passCount++;
        end
        @(negedge clk);
        rst = 1'b0;
        clearLanes();
    endtask

    task automatic test_single_source;
        @(negedge clk);
        driveLane(1, 1'b1, 32'hA1, 1'b0); #1;
        checkCount++; if (mBus.tvalid !== 1'b0) $display("[TB] FAIL single_idle_tvalid got=%0h exp=0", mBus.tvalid); else passCount++;
        checkCount++; if (grantValid !== 1'b0) $display("[TB] FAIL single_idle_grant got=%0h exp=0", grantValid); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grantValid !== 1'b1) $display("[TB] FAIL single_grant_valid got=%0h exp=1", grantValid); else passCount++;
        checkCount++; if (grantIdx !== 2'd1) $display("[TB] FAIL single_grant_idx got=%0d exp=1", grantIdx); else passCount++;
        checkCount++; if (mBus.tdata !== 32'hA1 || mBus.tvalid !== 1'b1) $display("[TB] FAIL single_beat0 got=%0h/%0h exp=a1/1", mBus.tdata, mBus.tvalid); else passCount++;
        checkCount++; if (sBus.tready !== 4'b0010) $display("[TB] FAIL single_s_tready got=%b exp=0010", sBus.tready); else passCount++;
        checkCount++; if (mBus.tkeep !== 4'hF || mBus.tid !== 1'b1) $display("[TB] FAIL single_keep_id got=%0h/%0h exp=f/1", mBus.tkeep, mBus.tid); else passCount++;
        @(negedge clk);
        driveLane(1, 1'b1, 32'hA2, 1'b0); #1;
        checkCount++; if (mBus.tdata !== 32'hA2 || mBus.tlast !== 1'b0) $display("[TB] FAIL single_beat1 got=%0h/%0h exp=a2/0", mBus.tdata, mBus.tlast); else passCount++;
        @(negedge clk);
        driveLane(1, 1'b1, 32'hA3, 1'b1); #1;
        checkCount++; if (mBus.tdata !== 32'hA3 || mBus.tlast !== 1'b1) $display("[TB] FAIL single_beat2 got=%0h/%0h exp=a3/1", mBus.tdata, mBus.tlast); else passCount++;
        @(negedge clk);
        driveLane(1, 1'b0, 32'h0, 1'b0); #1;
        checkCount++; if (grantValid !== 1'b0 || mBus.tvalid !== 1'b0) $display("[TB] FAIL single_release got=%0h/%0h exp=0/0", grantValid, mBus.tvalid); else passCount++;
        checkCount++; if (grantIdx !== 2'd1) $display("[TB] FAIL single_idx_hold got=%0d exp=1", grantIdx); else passCount++;
    endtask

    task automatic test_round_robin;
        int laneBeat [NI];
        int expOrder [5];
        int g;
`ifdef AXIS_ARB_FIXED_PRIORITY_EN
        expOrder = '{0, 0, 0, 0, 0};
`else
        expOrder = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < NI; i++) laneBeat[i] = 0;
        doReset();
        for (int p = 0; p < 5; p++) begin
            g = expOrder[p];
            @(negedge clk);
            for (int i = 0; i < NI; i++) driveLane(i, 1'b1, 32'(i*16 + laneBeat[i]), laneBeat[i] == 1);
            #1;
            checkCount++; if (grantValid !== 1'b0 || mBus.tvalid !== 1'b0) $display("[TB] FAIL rr_bubble pkt=%0d got=%0h/%0h exp=0/0", p, grantValid, mBus.tvalid); else passCount++;
            for (int b = 0; b < 2; b++) begin
                @(negedge clk);
                for (int i = 0; i < NI; i++) driveLane(i, 1'b1, 32'(i*16 + laneBeat[i]), laneBeat[i] == 1);
                #1;
                checkCount++; if (grantValid !== 1'b1 || grantIdx !== 2'(g)) $display("[TB] FAIL rr_grant pkt=%0d got=%0h/%0d exp=1/%0d", p, grantValid, grantIdx, g); else passCount++;
                checkCount++; if (mBus.tdata !== 32'(g*16 + b)) $display("[TB] FAIL rr_data pkt=%0d beat=%0d got=%0h exp=%0h", p, b, mBus.tdata, g*16 + b); else passCount++;
                laneBeat[g] = (laneBeat[g] + 1) % 2;
            end
        end
        @(negedge clk);
        clearLanes();
    endtask

    task automatic test_backpressure;
        int   b;
        logic rdy;
        doReset();
        @(negedge clk);
        driveLane(2, 1'b1, 32'hC0, 1'b0);
        driveLane(3, 1'b1, 32'hD0, 1'b1);
        mBus.tready = 1'b1; #1;
        checkCount++; if (grantValid !== 1'b0) $display("[TB] FAIL bp_idle got=%0h exp=0", grantValid); else passCount++;
        b = 0;
        rdy = 1'b1;
        for (int c = 0; c < 12 && b < 4; c++) begin
            @(negedge clk);
            driveLane(2, 1'b1, 32'hC0 + 32'(b), b == 3);
            mBus.tready = rdy; #1;
            checkCount++; if (mBus.tdata !== 32'hC0 + 32'(b) || mBus.tvalid !== 1'b1) $display("[TB] FAIL bp_data cyc=%0d got=%0h/%0h exp=%0h/1", c, mBus.tdata, mBus.tvalid, 32'hC0 + 32'(b)); else passCount++;
            checkCount++; if (sBus.tready !== (rdy ? 4'b0100 : 4'b0000)) $display("[TB] FAIL bp_s_tready cyc=%0d got=%b exp=%b", c, sBus.tready, rdy ? 4'b0100 : 4'b0000); else passCount++;
            checkCount++; if (grantIdx !== 2'd2) $display("[TB] FAIL bp_grant cyc=%0d got=%0d exp=2", c, grantIdx); else passCount++;
            if (rdy) b++;
            rdy = ~rdy;
        end
        checkCount++; if (b != 4) $display("[TB] FAIL bp_beats got=%0d exp=4", b); else passCount++;
        @(negedge clk);
        clearLanes();
        mBus.tready = 1'b1; #1;
        checkCount++; if (grantValid !== 1'b0 || mBus.tvalid !== 1'b0) $display("[TB] FAIL bp_release got=%0h/%0h exp=0/0", grantValid, mBus.tvalid); else passCount++;
    endtask

    task automatic test_lock;
        doReset();
        @(negedge clk);
        driveLane(0, 1'b1, 32'hE0, 1'b0);
        driveLane(2, 1'b1, 32'hF0, 1'b1); #1;
        checkCount++; if (grantValid !== 1'b0) $display("[TB] FAIL lock_idle got=%0h exp=0", grantValid); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grantIdx !== 2'd0 || mBus.tdata !== 32'hE0) $display("[TB] FAIL lock_first got=%0d/%0h exp=0/e0", grantIdx, mBus.tdata); else passCount++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            driveLane(0, 1'b0, 32'hE1, 1'b0); #1;
            checkCount++; if (mBus.tvalid !== 1'b0) $display("[TB] FAIL lock_stall_tvalid cyc=%0d got=%0h exp=0", k, mBus.tvalid); else passCount++;
            checkCount++; if (grantValid !== 1'b1 || grantIdx !== 2'd0) $display("[TB] FAIL lock_hold cyc=%0d got=%0h/%0d exp=1/0", k, grantValid, grantIdx); else passCount++;
            checkCount++; if (sBus.tready !== 4'b0001) $display("[TB] FAIL lock_s_tready cyc=%0d got=%b exp=0001", k, sBus.tready); else passCount++;
        end
        @(negedge clk);
        driveLane(0, 1'b1, 32'hE1, 1'b1); #1;
        checkCount++; if (mBus.tdata !== 32'hE1 || mBus.tlast !== 1'b1) $display("[TB] FAIL lock_last got=%0h/%0h exp=e1/1", mBus.tdata, mBus.tlast); else passCount++;
        @(negedge clk);
        driveLane(0, 1'b0, 32'h0, 1'b0); #1;
        checkCount++; if (grantValid !== 1'b0) $display("[TB] FAIL lock_bubble got=%0h exp=0", grantValid); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grantIdx !== 2'd2 || mBus.tdata !== 32'hF0) $display("[TB] FAIL lock_next got=%0d/%0h exp=2/f0", grantIdx, mBus.tdata); else passCount++;
        @(negedge clk);
        clearLanes(); #1;
        checkCount++; if (grantValid !== 1'b0) $display("[TB] FAIL lock_end got=%0h exp=0", grantValid); else passCount++;
    endtask

    task automatic test_reset_mid_packet;
        doReset();
        @(negedge clk);
        driveLane(1, 1'b1, 32'h51, 1'b0); #1;
        checkCount++; if (grantValid !== 1'b0) $display("[TB] FAIL rmp_idle got=%0h exp=0", grantValid); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grantIdx !== 2'd1 || mBus.tdata !== 32'h51) $display("[TB] FAIL rmp_beat0 got=%0d/%0h exp=1/51", grantIdx, mBus.tdata); else passCount++;
        @(negedge clk);
        driveLane(1, 1'b1, 32'h52, 1'b0);
        rst = 1'b1; #1;
        checkCount++; if (mBus.tvalid !== 1'b0) $display("[TB] FAIL rmp_abort_tvalid got=%0h exp=0", mBus.tvalid); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grantValid !== 1'b0 || mBus.tvalid !== 1'b0 || sBus.tready !== 4'b0000) $display("[TB] FAIL rmp_reset got=%0h/%0h/%b exp=0/0/0000", grantValid, mBus.tvalid, sBus.tready); else passCount++;
        rst = 1'b0;
        driveLane(1, 1'b1, 32'h61, 1'b1);
        driveLane(3, 1'b1, 32'h71, 1'b1);
        @(negedge clk); #1;
        checkCount++; if (grantIdx !== 2'd1 || mBus.tdata !== 32'h61) $display("[TB] FAIL rmp_fresh got=%0d/%0h exp=1/61", grantIdx, mBus.tdata); else passCount++;
        @(negedge clk);
        clearLanes(); #1;
        checkCount++; if (grantValid !== 1'b0) $display("[TB] FAIL rmp_end got=%0h exp=0", grantValid); else passCount++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        passCount  = 0;
        checkCount = 0;
        rst = 1'b1;
        mBus.tready = 1'b0;
        clearLanes();
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
